// File: rtl/periph_bus_fabric.sv
// periph_bus_fabric: N-slave base/mask decoded peripheral interconnect, one transaction in flight.
// Optional access timeout enabled by defining PERIPH_BUS_TIMEOUT_EN.
module periph_bus_fabric #(
    parameter int NUM_SLAVES = 5,
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter logic [NUM_SLAVES*AWIDTH-1:0] SLAVE_BASE = {
        32'h4000_0000, 32'h3000_0000, 32'h2000_0000,
        32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*AWIDTH-1:0] SLAVE_MASK = {
        32'hF000_0000, 32'hF000_0000, 32'hF000_0000,
        32'hF000_0000, 32'hF000_0000},
    parameter logic [NUM_SLAVES-1:0] ACK_MASK = '0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset_ff,
    input  logic                         m_req,
    input  logic                         m_we,
    input  logic [AWIDTH-1:0]            m_addr,
    input  logic [DWIDTH-1:0]            m_wdata,
    input  logic [DWIDTH/8-1:0]          m_be,
    output logic [DWIDTH-1:0]            m_rdata,
    output logic                         m_ready,
    output logic                         m_err,
    output logic [NUM_SLAVES-1:0]        s_cs_n,
    output logic                         s_we,
    output logic [AWIDTH-1:0]            s_addr,
    output logic [DWIDTH-1:0]            s_wdata,
    output logic [DWIDTH/8-1:0]          s_be,
    input  logic [NUM_SLAVES*DWIDTH-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ack
);

    localparam int BW = DWIDTH / 8;
    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || (DWIDTH % 8) != 0 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("periph_bus_fabric: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        DERR
    } state_t;

    state_t                  r_state;
    logic [IW-1:0]           r_idx;
    logic [NUM_SLAVES-1:0]   r_cs_n;
    logic                    r_we;
    logic [AWIDTH-1:0]       r_addr;
    logic [DWIDTH-1:0]       r_wdata;
    logic [BW-1:0]           r_be;
    logic [DWIDTH-1:0]       r_rdata;
    logic                    r_ready;
    logic                    r_err;

    logic                    w_hit;
    logic [IW-1:0]           w_idx;
    logic                    w_done;
    logic [DWIDTH-1:0]       w_sel_rdata;

`ifdef PERIPH_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]           r_cnt;
`endif

    // Address decode; scanning high to low lets the lowest matching index win
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[i*AWIDTH +: AWIDTH]) ==
                SLAVE_BASE[i*AWIDTH +: AWIDTH]) begin
                w_hit = 1'b1;
                w_idx = IW'(i);
            end
        end
    end

    // Completion of the selected slave: its ack, or immediate for fixed-latency slaves
    always_comb begin
        w_done      = ACK_MASK[r_idx] ? s_ack[r_idx] : 1'b1;
        w_sel_rdata = s_rdata[r_idx*DWIDTH +: DWIDTH];
    end

    // Transaction FSM with registered master and slave side outputs
    always_ff @(posedge clk or negedge reset_ff) begin
        if (!reset_ff) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cs_n  <= '1;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
`ifdef PERIPH_BUS_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    if (m_req) begin
                        r_we    <= m_we;
                        r_addr  <= m_addr;
                        r_wdata <= m_wdata;
                        r_be    <= m_be;
                        r_idx   <= w_idx;
                        if (w_hit) begin
                            r_cs_n  <= ~(NUM_SLAVES'(1) << w_idx);
                            r_state <= ACCESS;
`ifdef PERIPH_BUS_TIMEOUT_EN
                            r_cnt   <= '0;
`endif
                        end else begin
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                            r_state <= DERR;
                        end
                    end
                end
                ACCESS: begin
                    if (w_done) begin
                        r_cs_n  <= '1;
                        r_rdata <= r_we ? '0 : w_sel_rdata;
                        r_ready <= 1'b1;
                        r_err   <= 1'b0;
                        r_state <= RESP;
                    end
`ifdef PERIPH_BUS_TIMEOUT_EN
                    else if (r_cnt == TO_LAST) begin
                        r_cs_n  <= '1;
                        r_rdata <= '0;
                        r_ready <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                RESP, DERR: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m_rdata = r_rdata;
    assign m_ready = r_ready;
    assign m_err   = r_err;
    assign s_cs_n  = r_cs_n;
    assign s_we    = r_we;
    assign s_addr  = r_addr;
    assign s_wdata = r_wdata;
    assign s_be    = r_be;

endmodule

// File: tb/tb_periph_bus_fabric.sv
// tb_periph_bus_fabric: directed vector bench for periph_bus_fabric.
// Slaves 1 and 4 run in ack mode; the others have fixed 1-cycle latency.
module tb_periph_bus_fabric;

    logic        clk;
    logic        reset_ff;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        m_err;
    logic [4:0]  s_cs_n;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_be;
    logic [159:0] s_rdata;
    logic [4:0]  s_ack;

    int n_chk;
    int n_err;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          ack_cyc;
        logic [4:0]  spur;
        logic [4:0]  exp_cs_n;
        int          lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tv[9];
    vec_t lv;

    periph_bus_fabric #(
        .NUM_SLAVES(5),
        .AWIDTH(32),
        .DWIDTH(32),
        .ACK_MASK(5'b10010),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset_ff(reset_ff),
        .m_req(m_req),
        .m_we(m_we),
        .m_addr(m_addr),
        .m_wdata(m_wdata),
        .m_be(m_be),
        .m_rdata(m_rdata),
        .m_ready(m_ready),
        .m_err(m_err),
        .s_cs_n(s_cs_n),
        .s_we(s_we),
        .s_addr(s_addr),
        .s_wdata(s_wdata),
        .s_be(s_be),
        .s_rdata(s_rdata),
        .s_ack(s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        @(negedge clk);
        m_req   = 1'b1;
        m_we    = v.we;
        m_addr  = v.addr;
        m_wdata = v.wdata;
        m_be    = v.be;
        s_ack   = '0;
        @(posedge clk);
        for (int c = 1; c <= v.lat; c++) begin
            #1;
            s_ack = '0;
            if (c == 1) begin
                chk({nm, " s_we"}, 32'(s_we), 32'(v.we));
                chk({nm, " s_addr"}, s_addr, v.addr);
                chk({nm, " s_wdata"}, s_wdata, v.wdata);
                chk({nm, " s_be"}, 32'(s_be), 32'(v.be));
            end
            if (c < v.lat) begin
                chk({nm, " ready_wait"}, 32'(m_ready), 32'd0);
                chk({nm, " cs_n_access"}, 32'(s_cs_n), 32'(v.exp_cs_n));
                s_ack = v.spur | ((c == v.ack_cyc) ? ~v.exp_cs_n : 5'b0);
            end else begin
                chk({nm, " ready"}, 32'(m_ready), 32'd1);
                chk({nm, " err"}, 32'(m_err), 32'(v.exp_err));
                chk({nm, " rdata"}, m_rdata, v.exp_rdata);
                chk({nm, " cs_n_resp"}, 32'(s_cs_n), 32'h1f);
                m_req = 1'b0;
            end
            @(posedge clk);
        end
        #1;
        chk({nm, " ready_after"}, 32'(m_ready), 32'd0);
        chk({nm, " err_after"}, 32'(m_err), 32'd0);
        chk({nm, " rdata_hold"}, m_rdata, v.exp_rdata);
    endtask

    initial begin
        int nrdy;
        logic [31:0] b2b_rd[3];
        n_chk    = 0;
        n_err    = 0;
        reset_ff = 1'b0;
        m_req    = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_be     = '0;
        s_ack    = '0;
        s_rdata  = {32'h4444_0004, 32'h3333_0003, 32'hA5A5_0001,
                    32'h2222_0001, 32'h1111_0000};

        tv[0] = '{1'b0, 32'h2000_0010, 32'h0, 4'hF, 0, 5'b00000,
                  5'b11011, 2, 32'hA5A5_0001, 1'b0};
        tv[1] = '{1'b1, 32'h4000_0004, 32'h1234_5678, 4'b0011, 4, 5'b00010,
                  5'b01111, 5, 32'h0, 1'b0};
        tv[2] = '{1'b0, 32'hF000_0000, 32'h0, 4'hF, 0, 5'b00000,
                  5'b11111, 1, 32'h0, 1'b1};
        tv[3] = '{1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, 5'b00000,
                  5'b11110, 2, 32'h1111_0000, 1'b0};
        tv[4] = '{1'b0, 32'h1000_0008, 32'h0, 4'hF, 1, 5'b00000,
                  5'b11101, 2, 32'h2222_0001, 1'b0};
        tv[5] = '{1'b0, 32'h3000_000C, 32'h0, 4'hF, 0, 5'b10000,
                  5'b10111, 2, 32'h3333_0003, 1'b0};
        tv[6] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1100, 0, 5'b00000,
                  5'b11110, 2, 32'h0, 1'b0};
        tv[7] = '{1'b0, 32'h4000_0000, 32'h0, 4'hF, 2, 5'b00010,
                  5'b01111, 3, 32'h4444_0004, 1'b0};
        tv[8] = '{1'b1, 32'h5000_0000, 32'h1, 4'h1, 0, 5'b00000,
                  5'b11111, 1, 32'h0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst cs_n", 32'(s_cs_n), 32'h1f);
        chk("rst ready", 32'(m_ready), 32'd0);
        chk("rst err", 32'(m_err), 32'd0);
        chk("rst rdata", m_rdata, 32'h0);
        chk("rst s_addr", s_addr, 32'h0);
        chk("rst s_wdata", s_wdata, 32'h0);
        chk("rst s_be", 32'(s_be), 32'h0);
        chk("rst s_we", 32'(s_we), 32'h0);
        @(negedge clk);
        reset_ff = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_txn(tv[i], $sformatf("vec%0d", i));
        end

        // Reset asserted in the second ACCESS cycle of a waited read
        @(negedge clk);
        m_req  = 1'b1;
        m_we   = 1'b0;
        m_addr = 32'h1000_0000;
        s_ack  = '0;
        @(posedge clk);
        #1;
        chk("mrst cs_n_c1", 32'(s_cs_n), 32'h1d);
        @(posedge clk);
        #1;
        chk("mrst cs_n_c2", 32'(s_cs_n), 32'h1d);
        reset_ff = 1'b0;
        m_req    = 1'b0;
        #1;
        chk("mrst cs_n_now", 32'(s_cs_n), 32'h1f);
        chk("mrst ready_now", 32'(m_ready), 32'd0);
        chk("mrst rdata_now", m_rdata, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("mrst ready_hold", 32'(m_ready), 32'd0);
            chk("mrst cs_n_hold", 32'(s_cs_n), 32'h1f);
        end
        @(negedge clk);
        reset_ff = 1'b1;
        lv = '{1'b0, 32'h1000_0000, 32'h0, 4'hF, 2, 5'b00000,
               5'b11101, 3, 32'h2222_0001, 1'b0};
        run_txn(lv, "post_rst");

        // m_req held high across reads to slaves 0, 1, 0
        b2b_rd[0] = 32'h1111_0000;
        b2b_rd[1] = 32'h2222_0001;
        b2b_rd[2] = 32'h1111_0000;
        nrdy = 0;
        @(negedge clk);
        m_req  = 1'b1;
        m_we   = 1'b0;
        m_addr = 32'h0000_0000;
        s_ack  = 5'b00010;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (m_ready && nrdy < 3) begin
                chk($sformatf("b2b cycle%0d", nrdy), 32'(c), 32'(2 + 3 * nrdy));
                chk($sformatf("b2b rdata%0d", nrdy), m_rdata, b2b_rd[nrdy]);
                nrdy++;
                if (nrdy == 1) m_addr = 32'h1000_0000;
                else if (nrdy == 2) m_addr = 32'h0000_0000;
                else m_req = 1'b0;
            end
            @(posedge clk);
        end
        chk("b2b count", 32'(nrdy), 32'd3);
        m_req = 1'b0;
        s_ack = '0;

        // Ack arriving in the 16th ACCESS cycle completes normally
        lv = '{1'b0, 32'h1000_0000, 32'h0, 4'hF, 16, 5'b00000,
               5'b11101, 17, 32'h2222_0001, 1'b0};
        run_txn(lv, "ack16");

        // Slave 1 late ack: timeout build aborts, default build waits
`ifdef PERIPH_BUS_TIMEOUT_EN
        lv = '{1'b0, 32'h1000_0000, 32'h0, 4'hF, 20, 5'b00000,
               5'b11101, 17, 32'h0, 1'b1};
`else
        lv = '{1'b0, 32'h1000_0000, 32'h0, 4'hF, 20, 5'b00000,
               5'b11101, 21, 32'h2222_0001, 1'b0};
`endif
        run_txn(lv, "late_ack");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
